rca_seq: RTL and testbench
==========================

Name: rca_seq

Overview:
- Multi-cycle, parametrised adder/subtractor; successor to the combinational ripple-carry adder.
- Processes a W-bit operation D bits per clock through a D-bit ripple-carry slice and a registered carry.
- Trades latency for area; adds subtract mode, a start/busy/done handshake and held results.
- Sits as an ALU arithmetic unit behind the ALU control FSM.

Parameters:
- w, 16: operand/result width in bits; must be a multiple of d.
- d, 4: bits processed per cycle (slice width); 1 <= d <= w.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = x+y+cin, 1 = x+~y+1 (cin ignored); latched at start.
- x  input  w  operand A; latched at start.
- y  input  w  operand B; latched at start.
- cin  input  1  carry-in for add; latched at start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when z/cout/overflow become valid.
- z  output  w  result; held until next accepted start.
- cout  output  1  carry out of MSB (sub: 1 = no borrow).
- overflow  output  1  signed two's-complement overflow of the performed operation.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- N = w/d slices; slice k covers bits [k*d+d-1 : k*d].
- FSM states: IDLE, BUSY, DONE.
  - IDLE: start=1 at an edge latches x, y (inverted if sub), carry = (sub ? 1 : cin), slice counter = 0, next state BUSY. start=0 keeps IDLE.
  - BUSY: each edge adds slice k of the latched operands plus the carry register, writes the D-bit sum into z[slice k], updates the carry register and increments k. After slice N-1 (the N-th BUSY edge): cout = final carry, overflow computed, next state DONE.
  - DONE: lasts one cycle with done=1, then returns to IDLE. start in DONE is ignored; the earliest accept is the following IDLE cycle.
- Latency: start sampled at edge 0; done=1 in the cycle after edge N. Throughput is one operation per N+2 cycles.
- busy = 1 in BUSY only. done = 1 in DONE only.
- Overflow rule: a = x[w-1], b = effective y[w-1] (inverted for sub), s = z[w-1]; overflow = (~a & ~b & s) | (a & b & ~s).
- z, cout and overflow are undefined-free. z updates slice-wise during BUSY and must only be consumed when done=1. All three hold stable from DONE until the next accepted start.
- start while busy: ignored; no restart and no operand relatch.
- Inputs x, y, sub and cin may change freely after the start edge without affecting the result.
- Wrap-around: the result is modulo 2^w; the carry out is reported only via cout.
- d = w degenerates to a single BUSY cycle (latency 1).
- Reset (any state, including mid-BUSY): next state IDLE, busy=0, done=0, z=0, cout=0, overflow=0, carry register=0, counter=0. The operation in progress is aborted silently with no done pulse.
- Simultaneous rst and start: rst wins; start is not accepted.

Optional Feature:
- Macro: RCA_SEQ_SAT_EN.
- Defined: at the transition to DONE, if overflow=1, z is replaced by the signed saturation value. a=0 gives 0 followed by w-1 ones (0x7FFF for w=16); a=1 gives 1 followed by w-1 zeros (0x8000). cout and overflow still report the raw result.
- Undefined: z is always the wrapped modulo-2^w result.

Test Plan:
- w=16, d=4, sub=0, cin=0, x=50, y=32, start pulse -> busy for 4 cycles, done one cycle later, z=82, cout=0, overflow=0.
- sub=0, x=256, y=65535, cin=0 -> z=255, cout=1, overflow=0. Then x=0x7FFF, y=1 -> z=0x8000, overflow=1; with RCA_SEQ_SAT_EN, z=0x7FFF and overflow=1.
- sub=1, x=14, y=23 (cin=1 ignored) -> z=0xFFF7, cout=0, overflow=0. Then sub=1, x=0x8000, y=1 -> z=0x7FFF, overflow=1, cout=1; with RCA_SEQ_SAT_EN, z=0x8000.
- Start 1+2, then pulse start with x=100, y=100 and change x during BUSY -> result is still z=3 at done. The second start is ignored; no extra done pulse.
- Start 50+32, assert rst on the 2nd BUSY cycle -> next cycle busy=0, done=0, z=0; no done pulse follows. A fresh start then completes normally.
- Parameter sweep: d=1, 8 and 16 with x=0xFFFF, y=1, cin=1 -> z=0x0001, cout=1, overflow=0, done arriving after 16, 2 and 1 BUSY cycles respectively.

Source files
------------

// File: rtl/rca_seq.sv
// Multi-cycle ripple-carry adder/subtractor: a w-bit op is processed d bits per clock.
// Optional build macro RCA_SEQ_SAT_EN saturates z on signed overflow.

module rca_slice #(
    parameter int d = 4
) (
    input  logic [d-1:0] a,
    input  logic [d-1:0] b,
    input  logic         ci,
    output logic [d-1:0] s,
    output logic         co
);
    logic [d:0] c;

    assign c[0] = ci;
    for (genvar i = 0; i < d; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign co = c[d];
endmodule

module rca_seq #(
    parameter int w = 16,
    parameter int d = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [w-1:0] x,
    input  logic [w-1:0] y,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [w-1:0] z,
    output logic         cout,
    output logic         overflow
);
    localparam int N  = w / d;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Operand b is stored already conditioned for subtract.
    typedef struct packed {
        logic [w-1:0] a;
        logic [w-1:0] b;
    } opnd_t;

    state_t         state_q, state_d;
    opnd_t          op_q;
    logic [CW-1:0]  cnt_q;
    logic           carry_q;
    logic [w-1:0]   z_q;
    logic           cout_q;
    logic           ovf_q;

    logic           last;
    int             base;
    logic [d-1:0]   a_sl, b_sl, sum;
    logic           co;
    logic [w-1:0]   z_nxt, z_fin;
    logic           ovf_nxt;

    assign last = (cnt_q == CW'(N - 1));
    assign base = int'(cnt_q) * d;
    assign a_sl = op_q.a[base +: d];
    assign b_sl = op_q.b[base +: d];

    rca_slice #(.d(d)) u_slice (
        .a  (a_sl),
        .b  (b_sl),
        .ci (carry_q),
        .s  (sum),
        .co (co)
    );

    always_comb begin
        z_nxt              = z_q;
        z_nxt[base +: d]   = sum;
        ovf_nxt            = (~op_q.a[w-1] & ~op_q.b[w-1] &  z_nxt[w-1]) |
                             ( op_q.a[w-1] &  op_q.b[w-1] & ~z_nxt[w-1]);
        z_fin              = z_nxt;
`ifdef RCA_SEQ_SAT_EN
        // Clamp toward the sign of operand a; cout/overflow keep the raw result.
        if (ovf_nxt)
            z_fin = op_q.a[w-1] ? {1'b1, {(w-1){1'b0}}} : {1'b0, {(w-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            z_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    op_q.a  <= x;
                    op_q.b  <= sub ? ~y : y;
                    carry_q <= sub ? 1'b1 : cin;
                    cnt_q   <= '0;
                end
                BUSY: begin
                    z_q     <= last ? z_fin : z_nxt;
                    carry_q <= co;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last) begin
                        cout_q <= co;
                        ovf_q  <= ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_q == BUSY);
    assign done     = (state_q == DONE);
    assign z        = z_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_rca_seq.sv
// Bench for rca_seq: four instances (d=4,1,8,16) share stimulus and are checked
// every cycle against an arithmetic reference with per-instance timing.

module tb_rca_seq;
    localparam int W  = 16;
    localparam int NI = 4;

    function automatic int dsel(int g);
        return (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 16;
    endfunction

    logic clk = 1'b0;
    logic rst, start, sub, cin;
    logic [W-1:0] x, y;

    logic [NI-1:0] busy_v, done_v, cout_v, ovf_v;
    logic [W-1:0]  z_v [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        rca_seq #(.w(W), .d(dsel(g))) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .sub      (sub),
            .x        (x),
            .y        (y),
            .cin      (cin),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .z        (z_v[g]),
            .cout     (cout_v[g]),
            .overflow (ovf_v[g])
        );
    end

    // {cout, overflow, z} of one operation, from plain integer arithmetic
    function automatic logic [W+1:0] ref_op(logic [W-1:0] a, logic [W-1:0] b, logic s, logic ci);
        logic [W-1:0] be;
        logic [W:0]   r;
        logic         o;
        logic [W-1:0] zz;
        be = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (s ? 1'b1 : ci)};
        o  = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
        zz = r[W-1:0];
`ifdef RCA_SEQ_SAT_EN
        if (o) zz = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        return {r[W], o, zz};
    endfunction

    // Model: idle when timer==0; after accept, N busy cycles then one done cycle.
    int             m_timer [NI];
    logic [W+1:0]   m_pend  [NI];
    logic [W+1:0]   m_res   [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_timer[i] <= 0;
                m_res[i]   <= '0;
            end else if (m_timer[i] == 0) begin
                if (start) begin
                    m_pend[i]  <= ref_op(x, y, sub, cin);
                    m_timer[i] <= W / dsel(i) + 1;
                end
            end else begin
                m_timer[i] <= m_timer[i] - 1;
                if (m_timer[i] == 2) m_res[i] <= m_pend[i];
            end
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance to the next falling edge and compare every instance to the model.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(m_timer[i] >= 2));
            chk($sformatf("done[%0d]", i), 32'(done_v[i]), 32'(m_timer[i] == 1));
            if (m_timer[i] <= 1) begin
                chk($sformatf("z[%0d]", i),    32'(z_v[i]),    32'(m_res[i][W-1:0]));
                chk($sformatf("cout[%0d]", i), 32'(cout_v[i]), 32'(m_res[i][W+1]));
                chk($sformatf("ovf[%0d]", i),  32'(ovf_v[i]),  32'(m_res[i][W]));
            end
        end
    endtask

    task automatic pulse(logic [W-1:0] a, logic [W-1:0] b, logic s, logic ci);
        x = a; y = b; sub = s; cin = ci; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(string name);
        bit seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (done_v[0]) seen = 1;
            else tick();
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic lit(string name, logic [W-1:0] ez, logic ec, logic eo);
        chk({name, "_z"},    32'(z_v[0]),    32'(ez));
        chk({name, "_cout"}, 32'(cout_v[0]), 32'(ec));
        chk({name, "_ovf"},  32'(ovf_v[0]),  32'(eo));
    endtask

    initial begin
        int bcnt [NI];
        int dcnt [NI];
        int ndone;
        logic [W-1:0] sat_pos, sat_neg;
`ifdef RCA_SEQ_SAT_EN
        sat_pos = 16'h7FFF; sat_neg = 16'h8000;
`else
        sat_pos = 16'h8000; sat_neg = 16'h7FFF;
`endif
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; x = '0; y = '0;

        // Pin the reference model with hand-computed results
        chk("ref_50p32",   32'(ref_op(16'd50, 16'd32, 1'b0, 1'b0)),   32'h00052);
        chk("ref_wrap",    32'(ref_op(16'd256, 16'hFFFF, 1'b0, 1'b0)), 32'h200FF);
        chk("ref_sub",     32'(ref_op(16'd14, 16'd23, 1'b1, 1'b1)),   32'h0FFF7);
        chk("ref_ovf_add", 32'(ref_op(16'h7FFF, 16'd1, 1'b0, 1'b0)),  {14'd0, 2'b01, sat_pos});

        tick(); tick();
        lit("reset", 16'h0000, 1'b0, 1'b0);
        chk("reset_busy", 32'(busy_v), 32'h0);
        rst = 1'b0;
        tick();

        pulse(16'd50, 16'd32, 1'b0, 1'b0);
        chk("t1_busy_first", 32'(busy_v[0]), 32'd1);
        wait_done("t1");
        lit("t1", 16'd82, 1'b0, 1'b0);
        tick();

        pulse(16'd256, 16'hFFFF, 1'b0, 1'b0);
        wait_done("t2"); lit("t2", 16'd255, 1'b1, 1'b0); tick();

        pulse(16'h7FFF, 16'd1, 1'b0, 1'b0);
        wait_done("t3"); lit("t3", sat_pos, 1'b0, 1'b1); tick();

        pulse(16'd14, 16'd23, 1'b1, 1'b1);
        wait_done("t4"); lit("t4", 16'hFFF7, 1'b0, 1'b0); tick();

        pulse(16'h8000, 16'd1, 1'b1, 1'b0);
        wait_done("t5"); lit("t5", sat_neg, 1'b1, 1'b1); tick();

        // start while busy and input changes after accept must not matter
        pulse(16'd1, 16'd2, 1'b0, 1'b0);
        pulse(16'd100, 16'd100, 1'b0, 1'b0);
        x = 16'hABCD; y = 16'h1234;
        wait_done("t6"); lit("t6", 16'd3, 1'b0, 1'b0);
        tick();
        chk("t6_single_done", 32'(done_v[0]), 32'd0);
        repeat (20) tick();

        // reset on the second busy cycle aborts silently
        pulse(16'd50, 16'd32, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7_busy", 32'(busy_v[0]), 32'd0);
        chk("t7_done", 32'(done_v[0]), 32'd0);
        chk("t7_z",    32'(z_v[0]),    32'd0);
        ndone = 0;
        for (int k = 0; k < 8; k++) begin tick(); ndone += int'(done_v[0]); end
        chk("t7_no_done", 32'(ndone), 32'd0);
        pulse(16'd50, 16'd32, 1'b0, 1'b0);
        wait_done("t7b"); lit("t7b", 16'd82, 1'b0, 1'b0); tick();

        // rst and start together: rst wins
        rst = 1'b1; start = 1'b1; tick();
        rst = 1'b0; start = 1'b0;
        chk("t8_busy", 32'(busy_v), 32'h0);
        tick();
        chk("t8_still_idle", 32'(busy_v), 32'h0);

        // slice-width sweep: busy cycle counts 4,16,2,1
        for (int i = 0; i < NI; i++) begin bcnt[i] = 0; dcnt[i] = 0; end
        x = 16'hFFFF; y = 16'd1; sub = 1'b0; cin = 1'b1; start = 1'b1;
        for (int k = 0; k < 24; k++) begin
            tick();
            start = 1'b0;
            for (int i = 0; i < NI; i++) begin
                bcnt[i] += int'(busy_v[i]);
                if (done_v[i]) begin
                    dcnt[i]++;
                    chk($sformatf("sweep_z[%0d]", i),    32'(z_v[i]),    32'h0001);
                    chk($sformatf("sweep_cout[%0d]", i), 32'(cout_v[i]), 32'd1);
                    chk($sformatf("sweep_ovf[%0d]", i),  32'(ovf_v[i]),  32'd0);
                end
            end
        end
        chk("sweep_busy_d4",  32'(bcnt[0]), 32'd4);
        chk("sweep_busy_d1",  32'(bcnt[1]), 32'd16);
        chk("sweep_busy_d8",  32'(bcnt[2]), 32'd2);
        chk("sweep_busy_d16", 32'(bcnt[3]), 32'd1);
        for (int i = 0; i < NI; i++)
            chk($sformatf("sweep_done_cnt[%0d]", i), 32'(dcnt[i]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
